// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                             |
// | Description : Valid/ready issue stage for a combinational RV32I ALU.     |
// |               Macro ALU_BRANCH_EN adds branch compare decode and the     |
// |               BranchTaken output.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instr,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] ALUA,
    output logic [31:0] ALUB,
    output logic [3:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [31:0] Result,
    output logic        ZeroOut,
    output logic        Illegal
`ifdef ALU_BRANCH_EN
    ,
    output logic        BranchTaken
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
`ifdef ALU_BRANCH_EN
    localparam logic [6:0] c_OP_B    = 7'b1100011;
`endif

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1000;
    localparam logic [3:0] c_ALU_XOR  = 4'b1001;
    localparam logic [3:0] c_ALU_SLL  = 4'b1010;
    localparam logic [3:0] c_ALU_SRL  = 4'b1011;
    localparam logic [3:0] c_ALU_SRA  = 4'b1100;

    logic [1:0]  r_state;
    logic [31:0] r_instr;
    logic [31:0] r_srca;
    logic [31:0] r_srcb;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [3:0]  w_base;
    logic [3:0]  w_ctrl;
    logic [31:0] w_opb;
    logic        w_ill;
    logic        w_exec;
    logic        w_in_xfer;
    logic        w_unused;

    assign w_opc    = r_instr[6:0];
    assign w_f3     = r_instr[14:12];
    assign w_f7     = r_instr[31:25];
    assign w_unused = ^{r_instr[11:7], r_instr[19:15]};

    always_comb begin
        w_base = c_ALU_ADD;
        case (w_f3)
            3'b000:  w_base = c_ALU_ADD;
            3'b001:  w_base = c_ALU_SLL;
            3'b010:  w_base = c_ALU_SLT;
            3'b011:  w_base = c_ALU_SLTU;
            3'b100:  w_base = c_ALU_XOR;
            3'b101:  w_base = c_ALU_SRL;
            3'b110:  w_base = c_ALU_OR;
            default: w_base = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_ill  = 1'b1;
        w_ctrl = c_ALU_ADD;
        w_opb  = '0;
        case (w_opc)
            c_OP_R: begin
                w_opb = r_srcb;
                // the alternate funct7 only exists for SUB and SRA
                w_ill = !(w_f7 == c_F7_BASE ||
                          (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)));
                if (w_f7[5] && w_f3 == 3'b000)
                    w_ctrl = c_ALU_SUB;
                else if (w_f7[5] && w_f3 == 3'b101)
                    w_ctrl = c_ALU_SRA;
                else
                    w_ctrl = w_base;
            end
            c_OP_I: begin
                w_ctrl = w_base;
                if (w_f3 == 3'b001) begin
                    w_opb = {27'd0, r_instr[24:20]};
                    w_ill = (w_f7 != c_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_opb = {27'd0, r_instr[24:20]};
                    w_ill = !(w_f7 == c_F7_BASE || w_f7 == c_F7_ALT);
                    if (w_f7[5])
                        w_ctrl = c_ALU_SRA;
                end else begin
                    w_opb = {{20{r_instr[31]}}, r_instr[31:20]};
                    w_ill = 1'b0;
                end
            end
`ifdef ALU_BRANCH_EN
            c_OP_B: begin
                w_opb = r_srcb;
                case (w_f3)
                    3'b000, 3'b001: begin w_ctrl = c_ALU_SUB;  w_ill = 1'b0; end
                    3'b100, 3'b101: begin w_ctrl = c_ALU_SLT;  w_ill = 1'b0; end
                    3'b110, 3'b111: begin w_ctrl = c_ALU_SLTU; w_ill = 1'b0; end
                    default:        w_ill = 1'b1;
                endcase
            end
`endif
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_ctrl = c_ALU_ADD;
            w_opb  = '0;
        end
    end

`ifdef ALU_BRANCH_EN
    logic r_taken;
    logic w_taken;

    always_comb begin
        w_taken = 1'b0;
        if (w_opc == c_OP_B && !w_ill) begin
            case (w_f3)
                3'b000:  w_taken = Zero;
                3'b001:  w_taken = !Zero;
                3'b100,
                3'b110:  w_taken = ALUResult[0];
                default: w_taken = !ALUResult[0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_taken <= 1'b0;
        else if (w_exec)
            r_taken <= w_taken;
    end

    assign BranchTaken = r_taken;
`endif

    assign w_exec     = (r_state == c_EXEC);
    assign InReady    = (r_state == c_IDLE) || (r_state == c_DONE && OutReady);
    assign w_in_xfer  = InValid && InReady;
    assign ALUA       = (w_exec && !w_ill) ? r_srca : '0;
    assign ALUB       = w_exec ? w_opb : '0;
    assign ALUControl = w_exec ? w_ctrl : '0;
    assign OutValid   = (r_state == c_DONE);
    assign Result     = r_result;
    assign ZeroOut    = r_zero;
    assign Illegal    = r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_instr   <= '0;
            r_srca    <= '0;
            r_srcb    <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_instr <= Instr;
                r_srca  <= SrcA;
                r_srcb  <= SrcB;
            end
            case (r_state)
                c_IDLE: if (w_in_xfer) r_state <= c_EXEC;
                c_EXEC: begin
                    r_state   <= c_DONE;
                    r_result  <= w_ill ? '0 : ALUResult;
                    r_zero    <= Zero;
                    r_illegal <= w_ill;
                end
                c_DONE: if (OutReady) r_state <= w_in_xfer ? c_EXEC : c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_issue_ctrl                                          |
// | Description : Self-checking bench for alu_issue_ctrl with an ALU model,  |
// |               a transaction-level reference and random traffic.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUA;
    logic [31:0] ALUB;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] Result;
    logic        ZeroOut;
    logic        Illegal;
`ifdef ALU_BRANCH_EN
    logic        BranchTaken;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .Instr(Instr), .SrcA(SrcA), .SrcB(SrcB),
        .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero),
        .OutReady(OutReady), .OutValid(OutValid),
        .Result(Result), .ZeroOut(ZeroOut), .Illegal(Illegal)
`ifdef ALU_BRANCH_EN
        , .BranchTaken(BranchTaken)
`endif
    );

    // combinational ALU that the block drives
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            4'b0010: ALUResult = ALUA + ALUB;
            4'b0110: ALUResult = ALUA - ALUB;
            4'b0000: ALUResult = ALUA & ALUB;
            4'b0001: ALUResult = ALUA | ALUB;
            4'b1001: ALUResult = ALUA ^ ALUB;
            4'b0111: ALUResult = {31'd0, $signed(ALUA) < $signed(ALUB)};
            4'b1000: ALUResult = {31'd0, ALUA < ALUB};
            4'b1010: ALUResult = ALUA << ALUB[4:0];
            4'b1011: ALUResult = ALUA >> ALUB[4:0];
            4'b1100: ALUResult = 32'($signed(ALUA) >>> ALUB[4:0]);
            default: ALUResult = '0;
        endcase
    end
    assign Zero = (ALUResult == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction semantics straight from the RV32I definitions
    function automatic void ref_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                   output logic [3:0] ctrl, output logic [31:0] ea, output logic [31:0] eb,
                                   output logic [31:0] res, output logic ill, output logic taken);
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  s;
        logic        isr;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        ill = 1'b1; ctrl = 4'b0010; ea = '0; eb = '0; res = '0; taken = 1'b0;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            isr = (opc == 7'b0110011);
            ea  = a;
            eb  = isr ? b : ((f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm);
            s   = eb[4:0];
            ill = 1'b0;
            if (isr && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
            if (!isr && f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
            if (!isr && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
            case (f3)
                3'd0: if (isr && f7[5]) begin ctrl = 4'b0110; res = a - eb; end
                      else begin ctrl = 4'b0010; res = a + eb; end
                3'd1: begin ctrl = 4'b1010; res = a << s; end
                3'd2: begin ctrl = 4'b0111; res = ($signed(a) < $signed(eb)) ? 32'd1 : 32'd0; end
                3'd3: begin ctrl = 4'b1000; res = (a < eb) ? 32'd1 : 32'd0; end
                3'd4: begin ctrl = 4'b1001; res = a ^ eb; end
                3'd5: if (f7[5]) begin ctrl = 4'b1100; res = 32'($signed(a) >>> s); end
                      else begin ctrl = 4'b1011; res = a >> s; end
                3'd6: begin ctrl = 4'b0001; res = a | eb; end
                default: begin ctrl = 4'b0000; res = a & eb; end
            endcase
        end
`ifdef ALU_BRANCH_EN
        else if (opc == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
            ill = 1'b0; ea = a; eb = b;
            if (f3 == 3'd0 || f3 == 3'd1) begin
                ctrl = 4'b0110; res = a - b; taken = (f3 == 3'd0) ? (a == b) : (a != b);
            end else if (f3 == 3'd4 || f3 == 3'd5) begin
                ctrl = 4'b0111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                taken = ($signed(a) < $signed(b)) ^ f3[0];
            end else begin
                ctrl = 4'b1000; res = (a < b) ? 32'd1 : 32'd0; taken = (a < b) ^ f3[0];
            end
        end
`endif
        if (ill) begin
            ctrl = 4'b0010; ea = '0; eb = '0; res = '0; taken = 1'b0;
        end
    endfunction

    // transaction model: one op in flight, EXEC on the cycle after transfer, DONE after that
    int          cyc = 0;
    int          xfer_cyc = 0;
    bit          have_op = 1'b0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    always @(posedge clk) begin : b_mdl
        bit dn, rdy;
        dn  = have_op && (cyc > xfer_cyc);
        rdy = !have_op || (dn && OutReady);
        cyc++;
        if (reset) begin
            have_op = 1'b0;
        end else begin
            if (dn && OutReady) have_op = 1'b0;
            if (InValid && rdy) begin
                have_op = 1'b1; xfer_cyc = cyc;
                m_ins = Instr; m_a = SrcA; m_b = SrcB;
            end
        end
    end

    always @(negedge clk) begin : b_cmp
        logic [3:0]  ec;
        logic [31:0] ea, eb, er;
        logic        ei, et;
        bit          ex, dn, rdy;
        ref_op(m_ins, m_a, m_b, ec, ea, eb, er, ei, et);
        ex  = have_op && (cyc == xfer_cyc);
        dn  = have_op && (cyc > xfer_cyc);
        rdy = !have_op || (dn && OutReady);
        if (chk_on) begin
            chk("OutValid", OutValid, dn);
            chk("InReady", InReady, rdy);
            chk("ALUA", ALUA, ex ? ea : 32'd0);
            chk("ALUB", ALUB, ex ? eb : 32'd0);
            chk("ALUControl", ALUControl, ex ? ec : 4'd0);
            if (dn) begin
                chk("Result", Result, er);
                chk("ZeroOut", ZeroOut, er == 32'd0);
                chk("Illegal", Illegal, ei);
`ifdef ALU_BRANCH_EN
                chk("BranchTaken", BranchTaken, et);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        Instr = ins; SrcA = a; SrcB = b; InValid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = InReady;
            tick();
        end
        InValid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [31:0] r;
        logic [6:0]  f7;
        int          sel;
        w = $urandom; r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel <= 3) begin
            w[31:25] = ((w[14:12] == 3'd0 || w[14:12] == 3'd5) && r[0]) ? 7'h20 : 7'h00;
            w[6:0]   = 7'b0110011;
        end else if (sel <= 6) begin
            w[6:0] = 7'b0010011;
            if (w[14:12] == 3'd1) w[31:25] = 7'h00;
            else if (w[14:12] == 3'd5) w[31:25] = r[0] ? 7'h20 : 7'h00;
        end else if (sel == 7) begin
            f7 = 7'($urandom_range(1, 127));
            if (f7 == 7'h20) f7 = 7'h01;
            w[31:25] = f7;
            w[6:0]   = r[1] ? 7'b0110011 : 7'b0010011;
            if (!r[1]) w[14:12] = r[2] ? 3'd1 : 3'd5;
        end else if (sel == 8) begin
            w[6:0] = 7'b1100011;
        end else if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) begin
            w[6:0] = 7'b0000000;
        end
        return w;
    endfunction

    initial begin : b_stim
        logic [3:0]  pc;
        logic [31:0] pa, pb, pr;
        logic        pi, pt;
        reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Instr = '0; SrcA = '0; SrcB = '0;

        ref_op(32'h002081B3, 32'd5, 32'd7, pc, pa, pb, pr, pi, pt);
        chk("model_add", pr, 32'd12);
        ref_op(32'h4040D193, 32'h80000000, 32'd0, pc, pa, pb, pr, pi, pt);
        chk("model_srai", pr, 32'hF8000000);
        chk("model_srai_b", pb, 32'd4);

        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_OutValid", OutValid, 32'd0);
        chk("rst_Result", Result, 32'd0);
        chk("rst_ZeroOut", ZeroOut, 32'd0);
        chk("rst_Illegal", Illegal, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_InReady", InReady, 32'd1);
        OutReady = 1'b1;

        send(32'h002081B3, 32'd5, 32'd7);
        chk("add_ctrl", ALUControl, 32'b0010);
        chk("add_exec_valid", OutValid, 32'd0);
        tick();
        chk("add_valid", OutValid, 32'd1);
        chk("add_result", Result, 32'd12);
        chk("add_zero", ZeroOut, 32'd0);
        tick();

        send(32'h402081B3, 32'h1234, 32'h1234);
        chk("sub_ctrl", ALUControl, 32'b0110);
        tick();
        chk("sub_result", Result, 32'd0);
        chk("sub_zero", ZeroOut, 32'd1);
        tick();

        send(32'h4040D193, 32'h80000000, 32'h0);
        chk("srai_b", ALUB, 32'd4);
        chk("srai_ctrl", ALUControl, 32'b1100);
        tick();
        chk("srai_result", Result, 32'hF8000000);
        tick();

        OutReady = 1'b0;
        send(32'h002081B3, 32'd5, 32'd7);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_inready", InReady, 32'd0);
            chk("stall_valid", OutValid, 32'd1);
            chk("stall_result", Result, 32'd12);
            tick();
        end
        OutReady = 1'b1; InValid = 1'b1; Instr = 32'h402081B3; SrcA = 32'd9; SrcB = 32'd9;
        #1;
        chk("b2b_inready", InReady, 32'd1);
        tick();
        InValid = 1'b0;
        chk("b2b_exec_valid", OutValid, 32'd0);
        chk("b2b_exec_ctrl", ALUControl, 32'b0110);
        tick();
        chk("b2b_result", Result, 32'd0);
        tick();

        send(32'h00000000, 32'hDEAD, 32'hBEEF);
        chk("ill_a", ALUA, 32'd0);
        chk("ill_ctrl", ALUControl, 32'b0010);
        tick();
        chk("ill_flag", Illegal, 32'd1);
        chk("ill_result", Result, 32'd0);
        tick();

        send(32'h002081B3, 32'd1, 32'd2);
        reset = 1'b1;
        tick();
        chk("rst_exec_valid", OutValid, 32'd0);
        chk("rst_exec_inready", InReady, 32'd1);
        reset = 1'b0;
        tick();
        chk("rst_exec_valid2", OutValid, 32'd0);

`ifdef ALU_BRANCH_EN
        send(32'h0020C063, 32'hFFFFFFFF, 32'd1);
        chk("blt_ctrl", ALUControl, 32'b0111);
        tick();
        chk("blt_taken", BranchTaken, 32'd1);
        tick();
        send(32'h0020E063, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("bltu_taken", BranchTaken, 32'd0);
        tick();
`else
        send(32'h0020C063, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("branch_illegal", Illegal, 32'd1);
        tick();
`endif

        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            InValid  = ($urandom_range(0, 9) < 6);
            OutReady = ($urandom_range(0, 9) < 7);
            Instr    = gen_instr();
            SrcA     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            SrcB     = ($urandom_range(0, 3) == 0) ? SrcA : $urandom;
            tick();
        end
        reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
